// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : 8N1 UART transmitter with a valid/ready byte interface.
//               A byte is accepted on any rising edge where TX_VALID and
//               TX_READY are both high. The start bit is registered on that
//               same edge, followed by eight data bits (LSB first) and one
//               stop bit, each exactly CLKS_PER_BIT clocks long.
//
// Parameters  : CLKS_PER_BIT - CLK cycles per bit time (>= 2)
//
// Ports       : CLK       in   single clock, rising edge
//               nRST      in   asynchronous active-low reset
//               TX_DATA   in   [7:0] byte to send, sampled on accept
//               TX_VALID  in   source presents a byte
//               TX_READY  out  transmitter idle, can accept this cycle
//               BUSY      out  frame in progress (inverse of TX_READY)
//               UART_TX   out  registered serial line, idles high
//
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic       BUSY,
    output logic       UART_TX
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                  c_BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_ONE  = c_BAUD_W'(1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [c_BAUD_W-1:0] r_baud;
    logic [2:0]          r_bit;
    logic [7:0]          r_shift;
    logic                r_tx;

    logic [1:0]          w_state;
    logic [c_BAUD_W-1:0] w_baud;
    logic [2:0]          w_bit;
    logic [7:0]          w_shift;
    logic                w_tx;
    logic                w_baud_done;

    // Last clock of the current bit time.
    assign w_baud_done = (r_baud == c_BAUD_LAST);

    // ------------------------------------------------------------------------
    // State register. Reset drives the line high immediately, truncating any
    // frame in flight and discarding the latched byte.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= c_ST_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state;
            r_baud  <= w_baud;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_tx    <= w_tx;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state = r_state;
        w_baud  = r_baud;
        w_bit   = r_bit;
        w_shift = r_shift;

        case (r_state)
            c_ST_IDLE: begin
                // Baud counter stays parked in idle; it starts from zero
                // on the accepting edge.
                if (TX_VALID) begin
                    w_state = c_ST_START;
                    w_shift = TX_DATA;
                    w_bit   = '0;
                    w_baud  = '0;
                end
            end

            c_ST_START: begin
                if (w_baud_done) begin
                    w_baud  = '0;
                    w_state = c_ST_DATA;
                end else begin
                    w_baud = r_baud + c_BAUD_ONE;
                end
            end

            c_ST_DATA: begin
                if (w_baud_done) begin
                    w_baud  = '0;
                    w_shift = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state = c_ST_STOP;
                    end else begin
                        w_bit = r_bit + 3'd1;
                    end
                end else begin
                    w_baud = r_baud + c_BAUD_ONE;
                end
            end

            c_ST_STOP: begin
                if (w_baud_done) begin
                    w_baud  = '0;
                    w_state = c_ST_IDLE;
                end else begin
                    w_baud = r_baud + c_BAUD_ONE;
                end
            end

            default: begin
                w_state = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Line level is derived from the state being entered, so the start bit
    // appears on the accepting edge itself and each data bit appears on the
    // edge that shifts it into position 0.
    // ------------------------------------------------------------------------
    always_comb begin
        w_tx = 1'b1;
        case (w_state)
            c_ST_START: w_tx = 1'b0;
            c_ST_DATA:  w_tx = w_shift[0];
            default:    w_tx = 1'b1;
        endcase
    end

    assign TX_READY = (r_state == c_ST_IDLE);
    assign BUSY     = ~TX_READY;
    assign UART_TX  = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx. Two instances (4 and 2
//               clocks per bit) each get directed and random byte traffic.
//               Accepted bytes are queued with their accept cycle; a monitor
//               per instance detects each start bit, pops the expected byte
//               and compares the captured line waveform, the start latency
//               and the ready/busy levels against the frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    bit done [2];

    function automatic void check(input string name, input int inst,
                                  input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL inst%0d %s: got 0x%0h, expected 0x%0h", inst, name, act, exp);
        end
    endfunction

    // Expected line level for every clock of a frame: slot 0 is the start
    // bit, slots 1..8 are data bits LSB first, slot 9 is the stop bit.
    function automatic logic [63:0] frame_wave(input logic [7:0] d, input int n);
        logic [63:0] w;
        int          slot;
        w = '0;
        for (int p = 0; p < 10 * n; p++) begin
            slot = p / n;
            if (slot == 0)      w[p] = 1'b0;
            else if (slot == 9) w[p] = 1'b1;
            else                w[p] = d[slot-1];
        end
        return w;
    endfunction

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_inst
            localparam int N = (gi == 0) ? 4 : 2;

            logic       nrst;
            logic [7:0] tx_data;
            logic       tx_valid;
            logic       tx_ready;
            logic       busy;
            logic       line;

            logic [7:0] q_data [$];
            int         q_cyc  [$];
            int         idle_bad = 0;

            uart_tx #(.CLKS_PER_BIT(N)) u_dut (
                .CLK      (CLK),
                .nRST     (nrst),
                .TX_DATA  (tx_data),
                .TX_VALID (tx_valid),
                .TX_READY (tx_ready),
                .BUSY     (busy),
                .UART_TX  (line)
            );

            // ---------------- monitor / scoreboard ----------------
            initial begin : p_mon
                int          pos;
                logic [63:0] got;
                logic [63:0] expw;
                bit          rdy_bad;
                logic [7:0]  d;
                int          k;
                pos = -1; got = '0; expw = '0; rdy_bad = 1'b0;
                forever begin
                    @(negedge CLK);
                    if (!nrst) begin
                        pos = -1;
                        if ({line, tx_ready, busy} !== 3'b110) idle_bad++;
                    end else if (pos < 0) begin
                        if (line === 1'b0) begin
                            check("frame_expected", gi, (q_data.size() > 0), 1);
                            expw = '0;
                            if (q_data.size() > 0) begin
                                d = q_data.pop_front();
                                k = q_cyc.pop_front();
                                check("start_latency", gi, cyc, k);
                                expw = frame_wave(d, N);
                            end
                            got = '0; rdy_bad = 1'b0; pos = 0;
                        end else if (tx_ready !== 1'b1 || busy !== 1'b0) begin
                            idle_bad++;
                        end
                    end else if (pos == 10 * N) begin
                        check("frame_line", gi, got, expw);
                        check("ready_during_frame", gi, rdy_bad, 0);
                        check("ready_after_frame", gi, {line, tx_ready, busy}, 3'b110);
                        pos = -1;
                    end
                    if (nrst && pos >= 0 && pos < 10 * N) begin
                        got[pos] = line;
                        if (tx_ready !== 1'b0 || busy !== 1'b1) rdy_bad = 1'b1;
                        pos++;
                    end
                end
            end

            // Present a byte and wait (bounded) for the accepting edge.
            task automatic send_byte(input logic [7:0] d, input bit keep, output int acc);
                int waited = 0;
                acc = -1;
                @(negedge CLK);
                tx_data  = d;
                tx_valid = 1'b1;
                while (tx_ready !== 1'b1 && waited < 30 * N) begin
                    @(negedge CLK);
                    waited++;
                end
                if (tx_ready !== 1'b1) begin
                    check("accept_timeout", gi, tx_ready, 1);
                end else begin
                    acc = cyc + 1;
                    q_data.push_back(d);
                    q_cyc.push_back(acc);
                    @(posedge CLK);
                    #1;
                end
                if (!keep) tx_valid = 1'b0;
            endtask

            // ---------------- stimulus ----------------
            initial begin : p_stim
                int a0;
                int a1;
                nrst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
                #1 nrst = 1'b0;
                tx_valid = 1'b1; tx_data = 8'h5A;
                repeat (3) @(negedge CLK);
                check("reset_values", gi, {line, tx_ready, busy}, 3'b110);
                tx_valid = 1'b0;
                @(posedge CLK); #2 nrst = 1'b1;
                repeat (12) @(negedge CLK);
                check("idle_after_release", gi, {line, tx_ready, busy}, 3'b110);

                // single byte
                send_byte(8'h55, 1'b0, a0);
                repeat (10 * N + 2) @(negedge CLK);

                // back-to-back with valid held
                send_byte(8'h00, 1'b1, a0);
                send_byte(8'hFF, 1'b0, a1);
                check("b2b_period", gi, a1 - a0, 10 * N + 1);

                // valid while busy is ignored; data change after accept ignored
                send_byte(8'hC3, 1'b1, a0);
                @(negedge CLK); tx_data = 8'h3C;
                repeat (3 * N) @(negedge CLK);
                send_byte(8'hA3, 1'b0, a1);
                check("busy_ignore_period", gi, a1 - a0, 10 * N + 1);

                // MSB-only byte
                send_byte(8'h80, 1'b0, a0);

                // reset during data bit 3 (bit 3 of 0xF7 is 0)
                send_byte(8'hF7, 1'b0, a0);
                repeat (4 * N) @(posedge CLK);
                #2;
                check("line_in_bit3", gi, line, 0);
                nrst = 1'b0;
                #1;
                check("async_reset_levels", gi, {line, tx_ready, busy}, 3'b110);
                repeat (3) @(negedge CLK);
                @(posedge CLK); #2 nrst = 1'b1;
                #1;
                check("ready_after_reset", gi, {tx_ready, busy}, 2'b10);
                send_byte(8'h96, 1'b0, a0);

                // random traffic
                for (int i = 0; i < 16; i++) begin
                    send_byte(8'($urandom), 1'($urandom_range(0, 1)), a0);
                    repeat ($urandom_range(0, 3)) @(negedge CLK);
                end
                tx_valid = 1'b0;
                repeat (10 * N + 4) @(negedge CLK);

                check("idle_level_errors", gi, idle_bad, 0);
                check("pending_frames", gi, q_data.size(), 0);
                done[gi] = 1'b1;
            end
        end
    endgenerate

    initial begin : p_main
        wait (done[0] && done[1]);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : p_watchdog
        #600000;
        $display("FAIL watchdog: run incomplete, done=%0b%0b expected 11", done[1], done[0]);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
